// File: rtl/llc_ctrl_pkg.sv
// Shared types and sizes for the last-level cache controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package llc_ctrl_pkg;

    localparam int ADDR_W  = 32;
    localparam int WAYS    = 16;
    localparam int WAY_W   = 4;
    localparam int INDEX   = 14;
    localparam int OFFSET  = 6;
    localparam int TAG_W   = ADDR_W - INDEX - OFFSET;
    localparam int PLRU_W  = WAYS - 1;
    localparam int ENTRY_W = TAG_W + 2;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_INV   = 2'd2,
        OP_RSVD  = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_CMP, S_UPD, S_WB, S_FILL, S_WB_INV, S_RESP
    } ctrl_state_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             valid;
        logic             dirty;
    } way_entry_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/llc_ctrl_plru.sv
// Tree pseudo-LRU for one 16-way set: victim selection and access update.
// Latency: combinational.
// Backpressure: none.
// Ports: plru_in (set's tree bits), access_way -> victim_way, plru_out.
// Node 0 is the root, children of node i are 2i+1 / 2i+2, bit=0 means victim lies left.
module llc_plru
    import llc_ctrl_pkg::*;
(
    input  logic [PLRU_W-1:0] plru_in,
    input  logic [WAY_W-1:0]  access_way,
    output logic [WAY_W-1:0]  victim_way,
    output logic [PLRU_W-1:0] plru_out
);

    logic [3:0] v_node;
    logic [3:0] a_node;

    // Only nodes 0..14 are ever read, so the node index fits in 4 bits;
    // the wrap on the final (unused) step is harmless.
    always_comb begin
        v_node     = '0;
        victim_way = '0;
        for (int l = 0; l < WAY_W; l++) begin
            victim_way[WAY_W-1-l] = plru_in[v_node];
            v_node = {v_node[2:0], 1'b0} + 4'd1 + {3'b0, plru_in[v_node]};
        end
    end

    // Each node on the path is pointed away from the accessed way.
    always_comb begin
        a_node   = '0;
        plru_out = plru_in;
        for (int l = 0; l < WAY_W; l++) begin
            plru_out[a_node] = ~access_way[WAY_W-1-l];
            a_node = {a_node[2:0], 1'b0} + 4'd1 + {3'b0, access_way[WAY_W-1-l]};
        end
    end

endmodule

// File: rtl/llc_ctrl.sv
// Sequencing controller for the 16 MB 16-way 64 B-line LLC: lookup, PLRU replacement, writeback/fill, tag update.
// Latency: accept->rsp_valid 4 cycles on hit, 4 + memory handshake cycles on miss; req_ready returns 1 cycle later.
// Backpressure: one request at a time (req_ready low while busy); mem_valid held with stable cmd/addr until mem_ready.
// Ports: req_* front end, tag_*/plru_* external set arrays (read data valid cycle after tag_rd_en),
//        mem_* memory bus, rsp_* completion pulse. Define LLC_STATS_EN to add hit_cnt/miss_cnt/wb_cnt.
module llc_ctrl
    import llc_ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [1:0]              req_op,
    input  logic [ADDR_W-1:0]       req_addr,
    output logic                    tag_rd_en,
    output logic [INDEX-1:0]        tag_idx,
    input  logic [WAYS*ENTRY_W-1:0] tag_rd_data,
    input  logic [PLRU_W-1:0]       plru_rd_data,
    output logic                    tag_wr_en,
    output logic [WAY_W-1:0]        tag_wr_way,
    output logic [ENTRY_W-1:0]      tag_wr_entry,
    output logic                    plru_wr_en,
    output logic [PLRU_W-1:0]       plru_wr_data,
    output logic                    mem_valid,
    input  logic                    mem_ready,
    output logic                    mem_cmd,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic                    rsp_valid,
    output logic                    rsp_hit,
    output logic [WAY_W-1:0]        rsp_way
`ifdef LLC_STATS_EN
    ,
    output logic [31:0]             hit_cnt,
    output logic [31:0]             miss_cnt,
    output logic [31:0]             wb_cnt
`endif
);

    ctrl_state_t      state;
    op_t              op_q;
    logic [TAG_W-1:0] tag_q;

    way_entry_t       ent [WAYS];
    logic             hit, inv_found;
    logic [WAY_W-1:0] hit_way, inv_way, alloc_way, access_way, plru_victim;
    logic [PLRU_W-1:0] plru_new;
    way_entry_t       hit_ent, victim_ent;
    logic             is_inv, is_wr;

    assign is_inv = (op_q == OP_INV);
    assign is_wr  = (op_q == OP_WRITE);

    // Descending scan so the lowest matching / lowest invalid way wins.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            ent[w] = way_entry_t'(tag_rd_data[w*ENTRY_W +: ENTRY_W]);
        end
        for (int w = WAYS-1; w >= 0; w--) begin
            if (ent[w].valid && ent[w].tag == tag_q) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!ent[w].valid) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
    end

    assign alloc_way  = inv_found ? inv_way : plru_victim;
    assign access_way = hit ? hit_way : alloc_way;
    assign hit_ent    = ent[hit_way];
    assign victim_ent = ent[alloc_way];

    llc_plru u_plru (
        .plru_in    (plru_rd_data),
        .access_way (access_way),
        .victim_way (plru_victim),
        .plru_out   (plru_new)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            op_q         <= OP_READ;
            tag_q        <= '0;
            req_ready    <= 1'b1;
            tag_rd_en    <= 1'b0;
            tag_idx      <= '0;
            tag_wr_en    <= 1'b0;
            tag_wr_way   <= '0;
            tag_wr_entry <= '0;
            plru_wr_en   <= 1'b0;
            plru_wr_data <= '0;
            mem_valid    <= 1'b0;
            mem_cmd      <= 1'b0;
            mem_addr     <= '0;
            rsp_valid    <= 1'b0;
            rsp_hit      <= 1'b0;
            rsp_way      <= '0;
        end else begin
            tag_rd_en  <= 1'b0;
            tag_wr_en  <= 1'b0;
            plru_wr_en <= 1'b0;
            rsp_valid  <= 1'b0;
            case (state)
                S_IDLE: if (req_valid) begin
                    op_q      <= op_t'(req_op);
                    tag_q     <= req_addr[ADDR_W-1 -: TAG_W];
                    tag_idx   <= req_addr[OFFSET +: INDEX];
                    req_ready <= 1'b0;
                    tag_rd_en <= 1'b1;
                    state     <= S_RD;
                end
                S_RD: state <= S_CMP;
                S_CMP: begin
                    rsp_hit      <= hit;
                    rsp_way      <= hit ? hit_way : (is_inv ? '0 : alloc_way);
                    plru_wr_data <= plru_new;
                    if (is_inv) begin
                        tag_wr_way   <= hit_way;
                        tag_wr_entry <= {tag_q, 1'b0, 1'b0};
                        if (!hit) begin
                            rsp_valid <= 1'b1;
                            state     <= S_RESP;
                        end else if (hit_ent.dirty) begin
                            mem_valid <= 1'b1;
                            mem_cmd   <= 1'b1;
                            mem_addr  <= {tag_q, tag_idx, {OFFSET{1'b0}}};
                            state     <= S_WB_INV;
                        end else begin
                            tag_wr_en <= 1'b1;
                            state     <= S_UPD;
                        end
                    end else if (hit) begin
                        tag_wr_way   <= hit_way;
                        tag_wr_entry <= {tag_q, 1'b1, hit_ent.dirty | is_wr};
                        tag_wr_en    <= 1'b1;
                        plru_wr_en   <= 1'b1;
                        state        <= S_UPD;
                    end else begin
                        tag_wr_way   <= alloc_way;
                        tag_wr_entry <= {tag_q, 1'b1, is_wr};
                        mem_valid    <= 1'b1;
                        if (victim_ent.valid && victim_ent.dirty) begin
                            mem_cmd  <= 1'b1;
                            mem_addr <= {victim_ent.tag, tag_idx, {OFFSET{1'b0}}};
                            state    <= S_WB;
                        end else begin
                            mem_cmd  <= 1'b0;
                            mem_addr <= {tag_q, tag_idx, {OFFSET{1'b0}}};
                            state    <= S_FILL;
                        end
                    end
                end
                // mem_valid stays high straight into the fill transaction.
                S_WB: if (mem_ready) begin
                    mem_cmd  <= 1'b0;
                    mem_addr <= {tag_q, tag_idx, {OFFSET{1'b0}}};
                    state    <= S_FILL;
                end
                S_FILL: if (mem_ready) begin
                    mem_valid  <= 1'b0;
                    tag_wr_en  <= 1'b1;
                    plru_wr_en <= 1'b1;
                    state      <= S_UPD;
                end
                S_WB_INV: if (mem_ready) begin
                    mem_valid <= 1'b0;
                    tag_wr_en <= 1'b1;
                    state     <= S_UPD;
                end
                S_UPD: begin
                    rsp_valid <= 1'b1;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef LLC_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            wb_cnt   <= '0;
        end else begin
            if (state == S_RESP) begin
                if (rsp_hit) hit_cnt  <= sat_inc(hit_cnt);
                else         miss_cnt <= sat_inc(miss_cnt);
            end
            // mem_valid is always high in these states, so mem_ready alone is the handshake.
            if ((state == S_WB || state == S_WB_INV) && mem_ready)
                wb_cnt <= sat_inc(wb_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_llc_ctrl.sv
// Directed bench for llc_ctrl with tag/PLRU array and memory responder models.
// Latency: n/a.
// Backpressure: memory responder holds mem_ready low for a programmable number of cycles.
module tb_llc_ctrl;
    import llc_ctrl_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid, req_ready;
    logic [1:0]   req_op;
    logic [31:0]  req_addr;
    logic         tag_rd_en;
    logic [13:0]  tag_idx;
    logic [223:0] tag_rd_data = '0;
    logic [14:0]  plru_rd_data = '0;
    logic         tag_wr_en;
    logic [3:0]   tag_wr_way;
    logic [13:0]  tag_wr_entry;
    logic         plru_wr_en;
    logic [14:0]  plru_wr_data;
    logic         mem_valid;
    logic         mem_ready = 1'b0;
    logic         mem_cmd;
    logic [31:0]  mem_addr;
    logic         rsp_valid, rsp_hit;
    logic [3:0]   rsp_way;
`ifdef LLC_STATS_EN
    logic [31:0]  hit_cnt, miss_cnt, wb_cnt;
`endif

    always #5 clk = ~clk;

    llc_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
        .tag_rd_en(tag_rd_en), .tag_idx(tag_idx), .tag_rd_data(tag_rd_data), .plru_rd_data(plru_rd_data),
        .tag_wr_en(tag_wr_en), .tag_wr_way(tag_wr_way), .tag_wr_entry(tag_wr_entry),
        .plru_wr_en(plru_wr_en), .plru_wr_data(plru_wr_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_way(rsp_way)
`ifdef LLC_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
`endif
    );

    // ---------------- external tag / PLRU arrays ----------------
    logic [223:0] tagmem  [16384];
    logic [14:0]  plrumem [16384];
    logic         pre_wr = 1'b0;
    logic [13:0]  pre_idx = '0;
    logic [223:0] pre_tags = '0;
    logic [14:0]  pre_plru = '0;
    int           n_tagwr = 0;
    int           n_plruwr = 0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16384; i++) begin
                tagmem[i]  <= '0;
                plrumem[i] <= '0;
            end
        end else begin
            if (pre_wr) begin
                tagmem[pre_idx]  <= pre_tags;
                plrumem[pre_idx] <= pre_plru;
            end
            if (tag_rd_en) begin
                tag_rd_data  <= tagmem[tag_idx];
                plru_rd_data <= plrumem[tag_idx];
            end
            if (tag_wr_en) begin
                tagmem[tag_idx][tag_wr_way*14 +: 14] <= tag_wr_entry;
                n_tagwr <= n_tagwr + 1;
            end
            if (plru_wr_en) begin
                plrumem[tag_idx] <= plru_wr_data;
                n_plruwr <= n_plruwr + 1;
            end
        end
    end

    // ---------------- memory responder ----------------
    int          mem_delay = 0;
    int          wait_cnt = 0;
    int          mem_total = 0;
    int          stab_err = 0;
    logic [31:0] ref_addr = '0;
    logic        ref_cmd = 1'b0;
    logic [31:0] log_addr [256];
    logic        log_cmd  [256];

    // Decided on the falling edge; a handshake is logged when ready is raised
    // against a valid request, since the request cannot be withdrawn.
    always @(negedge clk) begin
        if (rst || !mem_valid) begin
            wait_cnt  = 0;
            mem_ready = 1'b0;
        end else begin
            if (wait_cnt == 0) begin
                ref_addr = mem_addr;
                ref_cmd  = mem_cmd;
            end else if (mem_addr !== ref_addr || mem_cmd !== ref_cmd) begin
                stab_err++;
            end
            if (wait_cnt >= mem_delay) begin
                mem_ready = 1'b1;
                log_addr[mem_total[7:0]] = mem_addr;
                log_cmd[mem_total[7:0]]  = mem_cmd;
                mem_total++;
                wait_cnt = 0;
            end else begin
                mem_ready = 1'b0;
                wait_cnt++;
            end
        end
    end

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
        int          dly;
        logic        hit;
        logic [3:0]  way;
        int          lat;
        int          nmem;
        logic        cmd0;
        logic [31:0] a0;
        logic [31:0] a1;
        int          ntag;
        int          nplru;
        logic [13:0] entry;
    } vec_t;

    localparam int NV = 24;
    vec_t vt [NV];

    function automatic vec_t mk(input logic [1:0] op, input logic [31:0] addr, input int dly,
                                input logic hit, input int way, input int lat, input int nmem,
                                input logic cmd0, input logic [31:0] a0, input logic [31:0] a1,
                                input int ntag, input int nplru, input logic [13:0] entry);
        vec_t v;
        v.op = op; v.addr = addr; v.dly = dly; v.hit = hit; v.way = 4'(way);
        v.lat = lat; v.nmem = nmem; v.cmd0 = cmd0; v.a0 = a0; v.a1 = a1;
        v.ntag = ntag; v.nplru = nplru; v.entry = entry;
        return v;
    endfunction

    task automatic do_req(input int k);
        int t, lat, b_tag, b_plru, b_mem, b_stab;
        logic [223:0] row;
        @(negedge clk);
        mem_delay = vt[k].dly;
        b_tag = n_tagwr; b_plru = n_plruwr; b_mem = mem_total; b_stab = stab_err;
        req_op = vt[k].op; req_addr = vt[k].addr; req_valid = 1'b1;
        t = 0;
        while (!req_ready && t < 50) begin @(negedge clk); t++; end
        chk($sformatf("v%0d accept", k), (t < 50), 1);
        // req_valid stays high while busy; the controller must ignore it.
        @(negedge clk);
        lat = 1;
        while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
        req_valid = 1'b0;
        chk($sformatf("v%0d latency", k), lat, vt[k].lat);
        chk($sformatf("v%0d rsp_hit", k), rsp_hit, vt[k].hit);
        chk($sformatf("v%0d rsp_way", k), rsp_way, vt[k].way);
        chk($sformatf("v%0d busy ready", k), req_ready, 0);
        chk($sformatf("v%0d mem count", k), mem_total - b_mem, vt[k].nmem);
        if (vt[k].nmem >= 1) begin
            chk($sformatf("v%0d mem cmd0", k), log_cmd[b_mem[7:0]], vt[k].cmd0);
            chk($sformatf("v%0d mem addr0", k), log_addr[b_mem[7:0]], vt[k].a0);
        end
        if (vt[k].nmem >= 2) begin
            chk($sformatf("v%0d mem cmd1", k), log_cmd[8'(b_mem + 1)], 0);
            chk($sformatf("v%0d mem addr1", k), log_addr[8'(b_mem + 1)], vt[k].a1);
        end
        chk($sformatf("v%0d mem stable", k), stab_err - b_stab, 0);
        chk($sformatf("v%0d tag writes", k), n_tagwr - b_tag, vt[k].ntag);
        chk($sformatf("v%0d plru writes", k), n_plruwr - b_plru, vt[k].nplru);
        row = tagmem[vt[k].addr[19:6]];
        chk($sformatf("v%0d entry", k), row[vt[k].way*14 +: 14], vt[k].entry);
        @(negedge clk);
        chk($sformatf("v%0d ready back", k), req_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_addr = '0;

        // op, addr, dly, hit, way, lat, nmem, cmd0, a0, a1, ntag, nplru, entry
        vt[0] = mk(OP_READ,  32'h0000_1040, 0, 0, 0, 5, 1, 0, 32'h0000_1040, 0, 1, 1, 14'h0002);
        vt[1] = mk(OP_READ,  32'h0000_1040, 0, 1, 0, 4, 0, 0, 0, 0, 1, 1, 14'h0002);
        vt[2] = mk(OP_WRITE, 32'h0000_1040, 0, 1, 0, 4, 0, 0, 0, 0, 1, 1, 14'h0003);
        vt[3] = mk(OP_RSVD,  32'h0000_1040, 0, 1, 0, 4, 0, 0, 0, 0, 1, 1, 14'h0003);
        vt[4] = mk(OP_READ,  32'h0010_0000, 0, 0, 0, 5, 1, 0, 32'h0010_0000, 0, 1, 1, 14'h0006);
        for (int tg = 2; tg <= 16; tg++)
            vt[tg+3] = mk(OP_WRITE, tg << 20, 0, 0, tg - 1, 5, 1, 0, tg << 20, 0, 1, 1,
                          14'((tg << 2) | 3));
        vt[20] = mk(OP_WRITE, 32'h0110_0000, 0, 0, 0, 5, 1, 0, 32'h0110_0000, 0, 1, 1, 14'h0047);
        vt[21] = mk(OP_WRITE, 32'h1230_0140, 10, 0, 0, 26, 2, 1, 32'hABC0_0140, 32'h1230_0140,
                    1, 1, 14'h048F);
        vt[22] = mk(OP_INV,   32'h1230_0140, 0, 1, 0, 5, 1, 1, 32'h1230_0140, 0, 1, 0, 14'h048C);
        vt[23] = mk(OP_INV,   32'h1230_0140, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 14'h048C);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset req_ready", req_ready, 1);
        chk("reset mem_valid", mem_valid, 0);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset tag_rd_en", tag_rd_en, 0);
        chk("reset tag_wr_en", tag_wr_en, 0);
        chk("reset plru_wr_en", plru_wr_en, 0);

        // Set 5: every way valid, way0 dirty with tag 0xABC, PLRU pointing at way0.
        for (int w = 0; w < 16; w++)
            pre_tags[w*14 +: 14] = (w == 0) ? {12'hABC, 1'b1, 1'b1} : {12'(12'h100 + w), 1'b1, 1'b0};
        pre_idx = 14'd5; pre_plru = '0; pre_wr = 1'b1;
        @(negedge clk);
        pre_wr = 1'b0;

        for (int k = 0; k < NV; k++) do_req(k);

        chk("set0 plru", plrumem[0], 15'h008B);
        chk("set5 plru", plrumem[5], 15'h008B);
`ifdef LLC_STATS_EN
        chk("hit_cnt", hit_cnt, 4);
        chk("miss_cnt", miss_cnt, 20);
        chk("wb_cnt", wb_cnt, 2);
`endif

        // Reset during a fill aborts the transaction on the next cycle.
        @(negedge clk);
        mem_delay = 50;
        req_op = OP_READ; req_addr = 32'h0000_0240; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        t = 0;
        while (!mem_valid && t < 20) begin @(negedge clk); t++; end
        chk("abort mem_valid seen", mem_valid, 1);
        chk("abort fill cmd", mem_cmd, 0);
        chk("abort fill addr", mem_addr, 32'h0000_0240);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort mem_valid", mem_valid, 0);
        chk("abort req_ready", req_ready, 1);
        chk("abort rsp_valid", rsp_valid, 0);
        chk("abort tag_wr_en", tag_wr_en, 0);
`ifdef LLC_STATS_EN
        chk("abort hit_cnt", hit_cnt, 0);
        chk("abort miss_cnt", miss_cnt, 0);
        chk("abort wb_cnt", wb_cnt, 0);
`endif
        rst = 1'b0;
        @(negedge clk);
        chk("abort idle ready", req_ready, 1);
        chk("abort idle mem_valid", mem_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
